// File: rtl/cp0_exc_sched_if.sv
// Commit-stage to CP0 exception sequencer signal bundle.
// slave = sequencer side, master = pipeline/CP0 environment side.
interface cp0_exc_sched_if;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_bd;
  logic [6:0]  mem_exc;
  logic [31:0] mem_badvaddr;
  logic        mem_eret;
  logic        cp0_int_pending;
  logic        cp0_exl;
  logic [31:0] cp0_epc;

  logic [6:0]  cp0_exc_vec;
  logic        cp0_exc_bd;
  logic [31:0] cp0_epc_in;
  logic [31:0] cp0_badvaddr;
  logic        cp0_eret;
  logic        flush;
  logic        stall_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport slave (
    input  mem_valid, mem_pc, mem_bd, mem_exc, mem_badvaddr, mem_eret,
    input  cp0_int_pending, cp0_exl, cp0_epc,
    output cp0_exc_vec, cp0_exc_bd, cp0_epc_in, cp0_badvaddr, cp0_eret,
    output flush, stall_if, redirect_valid, redirect_pc
  );

  modport master (
    output mem_valid, mem_pc, mem_bd, mem_exc, mem_badvaddr, mem_eret,
    output cp0_int_pending, cp0_exl, cp0_epc,
    input  cp0_exc_vec, cp0_exc_bd, cp0_epc_in, cp0_badvaddr, cp0_eret,
    input  flush, stall_if, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/cp0_exc_sched.sv
// Exception/interrupt/ERET sequencer: IDLE -> SIGNAL (CP0 strobe) -> REDIRECT (PC strobe).
// Optional macro CP0_SCHED_INT_EN lets cp0_int_pending take top priority.
module cp0_exc_sched #(
  parameter logic [31:0] EXC_ENTRY = 32'hBFC00380
) (
  input  logic             clk,
  input  logic             rst,
  cp0_exc_sched_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_SIGNAL, S_REDIRECT} state_t;
  typedef enum logic [1:0] {K_INT, K_EXC, K_ERET} kind_t;

  state_t      r_state;
  state_t      w_state_nxt;
  kind_t       r_kind;
  kind_t       w_kind;
  logic [6:0]  r_exc;
  logic [31:0] r_epc;
  logic        r_bd;
  logic [31:0] r_badvaddr;

  logic        w_int_evt;
  logic        w_exc_evt;
  logic        w_eret_evt;
  logic        w_accept;

  logic [6:0]  w_exc_vec;
  logic        w_eret;
  logic        w_flush;
  logic        w_stall;
  logic        w_redir_vld;
  logic [31:0] w_redir_pc;

`ifdef CP0_SCHED_INT_EN
  assign w_int_evt = bus.mem_valid && !bus.cp0_exl && bus.cp0_int_pending;
`else
  logic w_int_unused;
  assign w_int_unused = bus.cp0_int_pending;
  assign w_int_evt    = 1'b0;
`endif

  // ERET is the only event allowed while EXL is set
  assign w_exc_evt  = bus.mem_valid && !bus.cp0_exl && (|bus.mem_exc);
  assign w_eret_evt = bus.mem_valid && bus.mem_eret;
  assign w_accept   = (r_state == S_IDLE) && (w_int_evt || w_exc_evt || w_eret_evt);
  assign w_kind     = w_int_evt ? K_INT : (w_exc_evt ? K_EXC : K_ERET);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_kind     <= K_INT;
      r_exc      <= '0;
      r_epc      <= '0;
      r_bd       <= 1'b0;
      r_badvaddr <= '0;
    end else if (w_accept) begin
      r_kind     <= w_kind;
      r_exc      <= bus.mem_exc;
      r_epc      <= bus.mem_bd ? (bus.mem_pc - 32'd4) : bus.mem_pc;
      r_bd       <= bus.mem_bd;
      r_badvaddr <= bus.mem_exc[6] ? bus.mem_pc : bus.mem_badvaddr;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_exc_vec   = '0;
    w_eret      = 1'b0;
    w_flush     = 1'b0;
    w_stall     = 1'b0;
    w_redir_vld = 1'b0;
    w_redir_pc  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_SIGNAL;
      end
      S_SIGNAL: begin
        // interrupts leave the vector at zero; CP0 encodes ExcCode 0 itself
        w_flush     = 1'b1;
        w_stall     = 1'b1;
        w_exc_vec   = (r_kind == K_EXC) ? r_exc : 7'd0;
        w_eret      = (r_kind == K_ERET);
        w_state_nxt = S_REDIRECT;
      end
      S_REDIRECT: begin
        w_flush     = 1'b1;
        w_stall     = 1'b1;
        w_redir_vld = 1'b1;
        w_redir_pc  = (r_kind == K_ERET) ? bus.cp0_epc : EXC_ENTRY;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.cp0_exc_vec    = w_exc_vec;
  assign bus.cp0_eret       = w_eret;
  assign bus.flush          = w_flush;
  assign bus.stall_if       = w_stall;
  assign bus.redirect_valid = w_redir_vld;
  assign bus.redirect_pc    = w_redir_pc;
  assign bus.cp0_epc_in     = r_epc;
  assign bus.cp0_exc_bd     = r_bd;
  assign bus.cp0_badvaddr   = r_badvaddr;

endmodule

// File: tb/tb_cp0_exc_sched.sv
// Directed scoreboard bench for cp0_exc_sched; expectations adapt to CP0_SCHED_INT_EN.
module tb_cp0_exc_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  cp0_exc_sched_if bus ();

  cp0_exc_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string       name;
    bit          red;
    logic [6:0]  vec;
    logic        eret;
    logic [31:0] epc;
    logic        bd;
    logic [31:0] bva;
    logic [31:0] rpc;
  } exp_t;

  exp_t exp_q[$];

  task automatic push_pair(input string name, input logic [6:0] vec, input logic eret,
                           input logic [31:0] epc, input logic bd, input logic [31:0] bva,
                           input logic [31:0] rpc);
    exp_t e;
    e.name = {name, "_sig"}; e.red = 1'b0; e.vec = vec; e.eret = eret;
    e.epc = epc; e.bd = bd; e.bva = bva; e.rpc = '0;
    exp_q.push_back(e);
    e.name = {name, "_red"}; e.red = 1'b1; e.vec = '0; e.eret = 1'b0; e.rpc = rpc;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every cycle the DUT shows sequencer activity must match the queue head
  always @(negedge clk) begin
    if (bus.flush || bus.redirect_valid || bus.cp0_eret || (bus.cp0_exc_vec != 7'd0)) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: flush=%b rv=%b eret=%b vec=%h, expected idle",
                 bus.flush, bus.redirect_valid, bus.cp0_eret, bus.cp0_exc_vec);
      end else begin
        exp_t e;
        bit ok;
        e  = exp_q.pop_front();
        ok = (bus.redirect_valid === e.red) && (bus.flush === 1'b1) && (bus.stall_if === 1'b1) &&
             (bus.cp0_exc_vec === e.vec) && (bus.cp0_eret === e.eret) &&
             (bus.cp0_epc_in === e.epc) && (bus.cp0_exc_bd === e.bd) &&
             (bus.cp0_badvaddr === e.bva) && (!e.red || (bus.redirect_pc === e.rpc));
        if (!ok) begin
          fails++;
          $display("FAIL %s: got rv=%b fl=%b st=%b vec=%h eret=%b epc=%h bd=%b bva=%h rpc=%h, expected rv=%b fl=1 st=1 vec=%h eret=%b epc=%h bd=%b bva=%h rpc=%h",
                   e.name, bus.redirect_valid, bus.flush, bus.stall_if, bus.cp0_exc_vec,
                   bus.cp0_eret, bus.cp0_epc_in, bus.cp0_exc_bd, bus.cp0_badvaddr,
                   bus.redirect_pc, e.red, e.vec, e.eret, e.epc, e.bd, e.bva, e.rpc);
        end
      end
    end
  end

  task automatic clear_req();
    bus.mem_valid       = 1'b0;
    bus.mem_exc         = '0;
    bus.mem_eret        = 1'b0;
    bus.mem_bd          = 1'b0;
    bus.cp0_int_pending = 1'b0;
    bus.cp0_exl         = 1'b0;
  endtask

  // Present one request for a single cycle, then let the sequence drain
  task automatic issue(input logic [31:0] pc, input logic bd, input logic [6:0] exc,
                       input logic [31:0] bva, input logic eret, input logic intp,
                       input logic exl);
    bus.mem_valid       = 1'b1;
    bus.mem_pc          = pc;
    bus.mem_bd          = bd;
    bus.mem_exc         = exc;
    bus.mem_badvaddr    = bva;
    bus.mem_eret        = eret;
    bus.cp0_int_pending = intp;
    bus.cp0_exl         = exl;
    @(posedge clk); #1;
    clear_req();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    clear_req();
    bus.mem_pc       = '0;
    bus.mem_badvaddr = '0;
    bus.cp0_epc      = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_strobes", {25'd0, bus.cp0_exc_vec, bus.cp0_eret, bus.flush,
                            bus.stall_if, bus.redirect_valid}, 32'd0);
    check("reset_epc_in", bus.cp0_epc_in, 32'd0);
    check("reset_badvaddr", bus.cp0_badvaddr, 32'd0);
    check("reset_bd_rpc", {31'd0, bus.cp0_exc_bd} | bus.redirect_pc, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    push_pair("syscall", 7'h08, 1'b0, 32'hBFC00100, 1'b0, 32'h0, 32'hBFC00380);
    issue(32'hBFC00100, 1'b0, 7'h08, 32'h0, 1'b0, 1'b0, 1'b0);

    push_pair("ds_adel", 7'h02, 1'b0, 32'h80001000, 1'b1, 32'h00000003, 32'hBFC00380);
    issue(32'h80001004, 1'b1, 7'h02, 32'h00000003, 1'b0, 1'b0, 1'b0);

    push_pair("pc_adel", 7'h40, 1'b0, 32'h00000002, 1'b0, 32'h00000002, 32'hBFC00380);
    issue(32'h00000002, 1'b0, 7'h40, 32'h00001234, 1'b0, 1'b0, 1'b0);

    push_pair("epc_wrap", 7'h20, 1'b0, 32'hFFFFFFFC, 1'b1, 32'h00000055, 32'hBFC00380);
    issue(32'h00000000, 1'b1, 7'h20, 32'h00000055, 1'b0, 1'b0, 1'b0);

    // ERET with EXL set is still accepted; target is cp0_epc
    bus.cp0_epc = 32'hBFC00200;
    push_pair("eret", 7'h00, 1'b1, 32'h80000010, 1'b0, 32'h0, 32'hBFC00200);
    issue(32'h80000010, 1'b0, 7'h00, 32'h0, 1'b1, 1'b0, 1'b1);

    // exception while EXL=1 is not accepted
    issue(32'h80000020, 1'b0, 7'h10, 32'h0, 1'b0, 1'b0, 1'b1);
    check("exl_blocks_flush", {31'd0, bus.flush}, 32'd0);
    check("exl_keeps_epc", bus.cp0_epc_in, 32'h80000010);

`ifdef CP0_SCHED_INT_EN
    push_pair("int_ov", 7'h00, 1'b0, 32'h80000030, 1'b0, 32'h0, 32'hBFC00380);
`else
    push_pair("int_ov", 7'h10, 1'b0, 32'h80000030, 1'b0, 32'h0, 32'hBFC00380);
`endif
    issue(32'h80000030, 1'b0, 7'h10, 32'h0, 1'b0, 1'b1, 1'b0);

    push_pair("exc_over_eret", 7'h04, 1'b0, 32'h80000040, 1'b0, 32'h0, 32'hBFC00380);
    issue(32'h80000040, 1'b0, 7'h04, 32'h0, 1'b1, 1'b0, 1'b0);

    // back-to-back: T accepted, T+1/T+2 dropped, T+3 accepted
    push_pair("b2b_first", 7'h04, 1'b0, 32'h80000050, 1'b0, 32'h0, 32'hBFC00380);
    push_pair("b2b_second", 7'h01, 1'b0, 32'h8000005C, 1'b0, 32'h0, 32'hBFC00380);
    bus.mem_valid = 1'b1;
    bus.mem_pc    = 32'h80000050; bus.mem_exc = 7'h04;
    @(posedge clk); #1;
    bus.mem_pc    = 32'h80000054; bus.mem_exc = 7'h08;
    @(posedge clk); #1;
    bus.mem_pc    = 32'h80000058; bus.mem_exc = 7'h10;
    @(posedge clk); #1;
    bus.mem_pc    = 32'h8000005C; bus.mem_exc = 7'h01;
    @(posedge clk); #1;
    clear_req();
    repeat (3) @(posedge clk);
    #1;

    // reset during SIGNAL: strobe cycle is seen, redirect is not
    begin
      exp_t e;
      e.name = "rst_sig"; e.red = 1'b0; e.vec = 7'h08; e.eret = 1'b0;
      e.epc = 32'h80000060; e.bd = 1'b0; e.bva = 32'h0; e.rpc = '0;
      exp_q.push_back(e);
    end
    bus.mem_valid = 1'b1; bus.mem_pc = 32'h80000060; bus.mem_exc = 7'h08;
    @(posedge clk); #1;
    clear_req();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_sig_strobes", {25'd0, bus.cp0_exc_vec, bus.cp0_eret, bus.flush,
                              bus.stall_if, bus.redirect_valid}, 32'd0);
    check("rst_sig_epc_in", bus.cp0_epc_in, 32'd0);
    check("rst_sig_bd", {31'd0, bus.cp0_exc_bd}, 32'd0);
    @(negedge clk);
    check("rst_no_redirect", {31'd0, bus.redirect_valid}, 32'd0);

    // sequencer still works after a mid-sequence reset
    @(posedge clk); #1;
    push_pair("post_rst", 7'h10, 1'b0, 32'h80000070, 1'b0, 32'h0, 32'hBFC00380);
    issue(32'h80000070, 1'b0, 7'h10, 32'h0, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cp0_exc_sched.md
# cp0_exc_sched

Exception/interrupt/ERET sequencer between the commit (MEM) stage of the 5-stage pipeline and the CP0 register file. Picks one event per commit slot, drives CP0's exception-vector, EPC, BadVAddr and eret inputs for exactly one cycle, then flushes the pipeline and issues a single PC redirect. Serializes events so that CP0 never sees overlapping exception/eret requests.

## Interface
- EXC_ENTRY, 32'hBFC00380, exception entry PC (BEV=1 vector)
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; clock clk
- mem_valid  in  1  commit-stage instruction valid
- mem_pc  in  32  commit-stage PC
- mem_bd  in  1  commit-stage instruction is in a branch delay slot
- mem_exc  in  7  exception flags: [6] PC AdEL, [5] RI, [4] Ov, [3] Syscall, [2] Break, [1] AdEL, [0] AdES
- mem_badvaddr  in  32  faulting data address
- mem_eret  in  1  commit-stage instruction is ERET
- cp0_int_pending  in  1  CP0 unmasked interrupt pending and IE=1
- cp0_exl  in  1  CP0 Status.EXL
- cp0_epc  in  32  CP0 EPC value
- cp0_exc_vec  out  7  one-cycle exception vector to CP0
- cp0_exc_bd  out  1  BD flag to CP0
- cp0_epc_in  out  32  EPC value to CP0 (held)
- cp0_badvaddr  out  32  BadVAddr to CP0 (held)
- cp0_eret  out  1  one-cycle eret to CP0
- flush  out  1  kill all stages IF..MEM
- stall_if  out  1  freeze fetch
- redirect_valid  out  1  one-cycle redirect strobe
- redirect_pc  out  32  redirect target

## Operation
- States: IDLE, SIGNAL, REDIRECT. Reset -> IDLE; all outputs 0.
- Event evaluated in IDLE only, when mem_valid=1 and cp0_exl=0 (eret accepted regardless of cp0_exl). Priority: interrupt > exception (|mem_exc) > eret. Lower-priority events in same cycle dropped.
- Capture on accept: kind (INT/EXC/ERET), mem_exc, epc = mem_bd ? mem_pc-4 : mem_pc (32-bit wrap), bd = mem_bd, badvaddr = mem_exc[6] ? mem_pc : mem_badvaddr.
- Interrupt: cp0_exc_vec stays 0 (CP0 encodes ExcCode 0 itself); EPC/BD still driven.
- IDLE -> SIGNAL on accept. SIGNAL: cp0_exc_vec = captured vector (EXC) or cp0_eret=1 (ERET); flush=1. -> REDIRECT.
- REDIRECT: redirect_valid=1, flush=1; redirect_pc = EXC_ENTRY for INT/EXC, cp0_epc (sampled this cycle) for ERET. -> IDLE.
- stall_if=1 in SIGNAL and REDIRECT.
- cp0_epc_in, cp0_exc_bd, cp0_badvaddr hold last captured value until next accept (CP0 latches EPC continuously while EXL=0).
- Requests in SIGNAL/REDIRECT ignored (those instructions are being flushed).

## Timing
- Accept in cycle T (sampled at end of T). SIGNAL = T+1, REDIRECT = T+2, IDLE again T+3: earliest next accept T+3.
- cp0_exc_vec/cp0_eret asserted exactly 1 cycle (T+1); redirect_valid exactly 1 cycle (T+2); flush 2 cycles.
- cp0_epc_in valid from T+1 onward.
- rst in any state: next cycle IDLE, strobes/flush/stall 0, held registers 0.

## Configuration
- CP0_SCHED_INT_EN: defined -> cp0_int_pending participates as top priority. Undefined -> cp0_int_pending ignored; only exceptions and eret sequenced.

## Test plan
- Syscall: mem_valid=1, mem_pc=0xBFC00100, mem_exc=7'h08, bd=0 at T -> T+1 cp0_exc_vec=7'h08, cp0_epc_in=0xBFC00100, flush=1; T+2 redirect_pc=0xBFC00380.
- Delay-slot AdEL: mem_pc=0x80001004, bd=1, mem_exc=7'h02, mem_badvaddr=0x00000003 -> cp0_epc_in=0x80001000, cp0_exc_bd=1, cp0_badvaddr=0x00000003.
- ERET: mem_eret=1, cp0_epc=0xBFC00200 -> T+1 cp0_eret=1 only; T+2 redirect_valid=1, redirect_pc=0xBFC00200.
- Simultaneous int + Ov with macro on: cp0_int_pending=1, mem_exc=7'h10 -> cp0_exc_vec=0, redirect 0xBFC00380; with macro off -> cp0_exc_vec=7'h10.
- Back-to-back: exception at T and another at T+1, T+2 -> only T accepted; one redirect; new request at T+3 accepted.
- rst asserted in SIGNAL -> next cycle all outputs 0, state IDLE, no redirect pulse.
